// File: rtl/issue_scheduler_if.sv
// Bundle between the decode queue, the functional units and the issue
// scheduler. The scheduler attaches through the slave modport; the decode
// queue / unit side (or a testbench) drives through the master modport.
//
// Handshakes: a transfer happens on the rising clock edge where valid and
// ready are both high. queue_valid/queue_ready: allocation of one instruction
// into the table. issue_valid/unit_ready[issue_unit]: issue of the presented
// entry to that unit. writeback_valid has no ready; it completes
// writeback_id on the edge where it is high.
interface issue_scheduler_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int PACKET_WIDTH = DATA_WIDTH + 3*ADDRESS_BITS + 38,
    parameter int NUM_ENTRIES  = 4,
    parameter int NUM_UNITS    = 2,
    parameter int RD_BITS      = 5,
    parameter int ID_BITS      = $clog2(NUM_ENTRIES),
    parameter int UNIT_BITS    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
);
    logic [DATA_WIDTH-1:0]          instruction;
    logic [PACKET_WIDTH-1:0]        decode_packet;
    logic                           queue_valid;
    logic                           queue_ready;
    logic [NUM_UNITS-1:0]           unit_ready;
    logic                           issue_valid;
    logic [DATA_WIDTH-1:0]          issue_instruction;
    logic [PACKET_WIDTH-1:0]        issue_packet;
    logic [ID_BITS-1:0]             issue_id;
    logic [UNIT_BITS-1:0]           issue_unit;
    logic                           writeback_valid;
    logic [ID_BITS-1:0]             writeback_id;
    logic [NUM_ENTRIES*RD_BITS-1:0] rds_in_scheduler;
    logic [ID_BITS:0]               occupancy;
    // Per-entry state (2 bits each, entry 0 in the low bits) for observation.
    logic [2*NUM_ENTRIES-1:0]       entry_states;

    modport master (
        output instruction, decode_packet, queue_valid, unit_ready,
               writeback_valid, writeback_id,
        input  queue_ready, issue_valid, issue_instruction, issue_packet,
               issue_id, issue_unit, rds_in_scheduler, occupancy, entry_states
    );

    modport slave (
        input  instruction, decode_packet, queue_valid, unit_ready,
               writeback_valid, writeback_id,
        output queue_ready, issue_valid, issue_instruction, issue_packet,
               issue_id, issue_unit, rds_in_scheduler, occupancy, entry_states
    );
endinterface

// File: rtl/issue_scheduler.sv
// Out-of-order issue scheduler: a table of decoded instructions, each FREE,
// WAITING or ISSUED. The oldest hazard-free WAITING entry with a ready unit is
// issued each cycle; a writeback returns its entry to FREE. Age is kept as a
// matrix: older_q[i][j] set means entry j is older than entry i.
module issue_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int PACKET_WIDTH = DATA_WIDTH + 3*ADDRESS_BITS + 38,
    parameter int NUM_ENTRIES  = 4,
    parameter int NUM_UNITS    = 2,
    parameter int RD_BITS      = 5,
    parameter int ID_BITS      = $clog2(NUM_ENTRIES),
    parameter int UNIT_BITS    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input logic              clock,
    input logic              reset,
    issue_scheduler_if.slave sched
);
    typedef enum logic [1:0] {
        ENTRY_FREE    = 2'd0,
        ENTRY_WAITING = 2'd1,
        ENTRY_ISSUED  = 2'd2
    } entry_state_t;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0001111) ||
               (op == 7'b1110011) || (op == 7'b1101111);
    endfunction

    entry_state_t            state_q [NUM_ENTRIES];
    entry_state_t            state_d [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]   instr_q [NUM_ENTRIES];
    logic [PACKET_WIDTH-1:0] packet_q[NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  older_q [NUM_ENTRIES];
    logic [ID_BITS:0]        occ_q;

    logic [NUM_ENTRIES-1:0]  busy, waiting, is_mem, writes_rd;
    logic [NUM_ENTRIES-1:0]  blocked, eligible, cand, sel_oh;
    logic [RD_BITS-1:0]      rd_f [NUM_ENTRIES];
    logic [RD_BITS-1:0]      rs1_f[NUM_ENTRIES];
    logic [RD_BITS-1:0]      rs2_f[NUM_ENTRIES];
    logic [UNIT_BITS-1:0]    alu_unit;
    logic                    alu_ok;
    logic                    sel_valid;
    logic [ID_BITS-1:0]      sel_id;
    logic [UNIT_BITS-1:0]    sel_unit;
    logic [ID_BITS-1:0]      alloc_id;
    logic                    alloc_fire, issue_fire, wb_fire;

    // Per-entry decode of state, class and register fields.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            busy[i]      = (state_q[i] != ENTRY_FREE);
            waiting[i]   = (state_q[i] == ENTRY_WAITING);
            is_mem[i]    = is_mem_op(instr_q[i][6:0]);
            writes_rd[i] = packet_q[i][0];
            rd_f[i]      = instr_q[i][7 +: RD_BITS];
            rs1_f[i]     = instr_q[i][15 +: RD_BITS];
            rs2_f[i]     = instr_q[i][20 +: RD_BITS];
        end
    end

    // Hazard check against every older live entry: register overlap with a
    // pending writer, and memory ops stay behind older un-issued memory ops.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (older_q[i][j] && busy[j]) begin
                    if (writes_rd[j] && (rd_f[j] != '0) &&
                        ((rd_f[j] == rs1_f[i]) || (rd_f[j] == rs2_f[i]) || (rd_f[j] == rd_f[i])))
                        blocked[i] = 1'b1;
                    if (is_mem[i] && is_mem[j] && waiting[j])
                        blocked[i] = 1'b1;
                end
            end
        end
    end

    assign eligible = waiting & ~blocked;

    // ALU target: lowest ready unit above 0, falling back to unit 0.
    always_comb begin
        alu_unit = '0;
        alu_ok   = 1'b0;
        for (int u = NUM_UNITS - 1; u >= 1; u--) begin
            if (sched.unit_ready[u]) begin
                alu_unit = UNIT_BITS'(u);
                alu_ok   = 1'b1;
            end
        end
        if (!alu_ok && sched.unit_ready[0]) begin
            alu_unit = '0;
            alu_ok   = 1'b1;
        end
    end

    // Oldest candidate wins; live entries are totally ordered so at most one bit is set.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        sel_unit  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            cand[i] = eligible[i] && (is_mem[i] ? sched.unit_ready[0] : alu_ok);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_oh[i] = cand[i] && ((cand & older_q[i]) == '0);
            if (sel_oh[i]) begin
                sel_valid = 1'b1;
                sel_id    = ID_BITS'(i);
                sel_unit  = is_mem[i] ? '0 : alu_unit;
            end
        end
    end

    // Lowest-index free entry receives the next allocation.
    always_comb begin
        alloc_id = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!busy[i]) alloc_id = ID_BITS'(i);
    end

    assign sched.queue_ready = ~(&busy);
    assign alloc_fire        = sched.queue_valid && sched.queue_ready;
    assign issue_fire        = sel_valid && sched.unit_ready[sel_unit];
    assign wb_fire           = sched.writeback_valid &&
                               (int'(sched.writeback_id) < NUM_ENTRIES) &&
                               (state_q[sched.writeback_id] == ENTRY_ISSUED);

    // Entry next-state: allocate, issue and free always hit different entries.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) state_d[i] = state_q[i];
        if (alloc_fire) state_d[alloc_id]           = ENTRY_WAITING;
        if (issue_fire) state_d[sel_id]             = ENTRY_ISSUED;
        if (wb_fire)    state_d[sched.writeback_id] = ENTRY_FREE;
    end

    // Entry state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= ENTRY_FREE;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= state_d[i];
        end
    end

    // Payload and age capture on allocation; the new entry is younger than all live ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                instr_q[i]  <= '0;
                packet_q[i] <= '0;
                older_q[i]  <= '0;
            end
        end else if (alloc_fire) begin
            instr_q[alloc_id]  <= sched.instruction;
            packet_q[alloc_id] <= sched.decode_packet;
            for (int j = 0; j < NUM_ENTRIES; j++) older_q[j][alloc_id] <= 1'b0;
            older_q[alloc_id] <= busy;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_q + (ID_BITS+1)'(alloc_fire) - (ID_BITS+1)'(wb_fire);
    end

    // Issue outputs are NOP/zero unless a candidate is presented.
    always_comb begin
        sched.issue_instruction = NOP_INSTR;
        sched.issue_packet      = '0;
        sched.issue_id          = '0;
        sched.issue_unit        = '0;
        if (sel_valid) begin
            sched.issue_instruction = instr_q[sel_id];
            sched.issue_packet      = packet_q[sel_id];
            sched.issue_id          = sel_id;
            sched.issue_unit        = sel_unit;
        end
    end

    // Status: destination registers of live entries and per-entry state.
    always_comb begin
        sched.rds_in_scheduler = '0;
        sched.entry_states     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sched.rds_in_scheduler[i*RD_BITS +: RD_BITS] = busy[i] ? rd_f[i] : '0;
            sched.entry_states[2*i +: 2]                 = state_q[i];
        end
    end

    assign sched.issue_valid = sel_valid;
    assign sched.occupancy   = occ_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: expected issues (unit, id, instruction)
// are queued as stimulus is driven and popped when an issue fires.
module tb_issue_scheduler;
    localparam int PW = 130;
    localparam int W  = 1 + 2 + 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_scheduler_if bus ();
    issue_scheduler dut (.clock(clk), .reset(rst), .sched(bus));

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] add_r(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1);
        return {12'b0, 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b010, 5'b0, 7'h23};
    endfunction
    function automatic logic [PW-1:0] pkt(input logic [31:0] ins, input logic rw);
        logic [PW-1:0] p;
        p      = '0;
        p[32:1] = ins;
        p[0]   = rw;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input logic [31:0] ins, input int id, input int unit);
        exp_q.push_back({1'(unit), 2'(id), ins});
    endtask

    task automatic drive(input logic qv, input logic [31:0] ins, input logic rw,
                         input logic [1:0] ur, input logic wv, input int wid);
        bus.queue_valid     = qv;
        bus.instruction     = ins;
        bus.decode_packet   = pkt(ins, rw);
        bus.unit_ready      = ur;
        bus.writeback_valid = wv;
        bus.writeback_id    = 2'(wid);
        #1;
    endtask

    // Sample at the falling edge, score any issue, then step past the rising edge.
    task automatic tick();
        logic [W-1:0] e;
        @(negedge clk);
        if (bus.issue_valid === 1'b1 && bus.unit_ready[bus.issue_unit] === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL issue_unexpected observed=%0h expected=none",
                       {bus.issue_unit, bus.issue_id, bus.issue_instruction});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("issue", 160'({bus.issue_unit, bus.issue_id, bus.issue_instruction}), 160'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] a[4];
    logic [31:0] t[4];
    logic [31:0] f, p, q, r, w, l, s, u;

    initial begin
        for (int k = 0; k < 4; k++) begin
            a[k] = addi(k + 1, 0, k + 1);
            t[k] = addi(11 + k, 0, k);
        end
        f = addi(10, 0, 10);
        p = add_r(5, 1, 2);
        q = add_r(6, 5, 3);
        r = add_r(7, 1, 2);
        w = addi(8, 0, 1);
        l = lw(7, 8);
        s = sw(9, 1);
        u = addi(20, 0, 5);

        // Reset state
        drive(0, NOP, 0, 2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_queue_ready", bus.queue_ready, 1);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_issue_instr", bus.issue_instruction, NOP);
        chk("rst_issue_packet", bus.issue_packet, 0);
        chk("rst_issue_id", bus.issue_id, 0);
        chk("rst_issue_unit", bus.issue_unit, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_rds", bus.rds_in_scheduler, 0);
        rst = 1'b0;

        // Independent ALU stream with prompt writebacks
        drive(1, a[0], 1, 2'b11, 0, 0); tick();
        chk("t1_occ_e1", bus.occupancy, 1);
        drive(1, a[1], 1, 2'b11, 0, 0); expect_issue(a[0], 0, 1);
        chk("t1_first_unit", bus.issue_unit, 1);
        chk("t1_packet", bus.issue_packet, pkt(a[0], 1));
        tick();
        chk("t1_occ_e2", bus.occupancy, 2);
        drive(1, a[2], 1, 2'b11, 1, 0); expect_issue(a[1], 1, 1); tick();
        chk("t1_occ_e3", bus.occupancy, 2);
        chk("t1_qready", bus.queue_ready, 1);
        drive(1, a[3], 1, 2'b11, 1, 1); expect_issue(a[2], 2, 1); tick();
        chk("t1_occ_e4", bus.occupancy, 2);
        drive(0, NOP, 0, 2'b11, 1, 2); expect_issue(a[3], 0, 1); tick();
        chk("t1_occ_e5", bus.occupancy, 1);
        drive(0, NOP, 0, 2'b11, 1, 0); tick();
        chk("t1_occ_e6", bus.occupancy, 0);

        // Full table, hold-off and writeback to a WAITING entry
        for (int k = 0; k < 4; k++) begin
            drive(1, a[k], 1, 2'b00, 0, 0); tick();
        end
        chk("t2_occ_full", bus.occupancy, 4);
        chk("t2_qready_full", bus.queue_ready, 0);
        chk("t2_no_issue", bus.issue_valid, 0);
        chk("t2_rds", bus.rds_in_scheduler, {5'd4, 5'd3, 5'd2, 5'd1});
        drive(1, f, 1, 2'b00, 1, 1); tick();
        chk("t2_wb_waiting_occ", bus.occupancy, 4);
        chk("t2_wb_waiting_qready", bus.queue_ready, 0);
        drive(1, f, 1, 2'b11, 0, 0);
        chk("t2_issue_valid", bus.issue_valid, 1);
        chk("t2_issue_id", bus.issue_id, 0);
        expect_issue(a[0], 0, 1); tick();
        drive(1, f, 1, 2'b11, 1, 0); expect_issue(a[1], 1, 1);
        chk("t2_qready_hold", bus.queue_ready, 0);
        tick();
        chk("t2_occ_after_free", bus.occupancy, 3);
        chk("t2_qready_free", bus.queue_ready, 1);
        drive(1, f, 1, 2'b11, 1, 1); expect_issue(a[2], 2, 1); tick();
        chk("t2_occ_alloc", bus.occupancy, 3);
        drive(0, NOP, 0, 2'b11, 1, 2); expect_issue(a[3], 3, 1); tick();
        drive(0, NOP, 0, 2'b11, 1, 3); expect_issue(f, 0, 1); tick();
        drive(0, NOP, 0, 2'b11, 1, 0); tick();
        chk("t2_occ_drain", bus.occupancy, 0);

        // RAW blocking and out-of-order issue
        drive(1, p, 1, 2'b11, 0, 0); tick();
        drive(1, q, 1, 2'b11, 0, 0); expect_issue(p, 0, 1); tick();
        drive(1, r, 1, 2'b11, 0, 0);
        chk("t3_raw_blocked", bus.issue_valid, 0);
        tick();
        drive(0, NOP, 0, 2'b11, 0, 0);
        chk("t3_ooo_id", bus.issue_id, 2);
        expect_issue(r, 2, 1); tick();
        drive(0, NOP, 0, 2'b11, 1, 0);
        chk("t3_still_blocked", bus.issue_valid, 0);
        chk("t3_nop_idle", bus.issue_instruction, NOP);
        tick();
        drive(0, NOP, 0, 2'b11, 0, 0);
        chk("t3_unblocked_id", bus.issue_id, 1);
        expect_issue(q, 1, 1); tick();
        drive(0, NOP, 0, 2'b11, 1, 1); tick();
        drive(0, NOP, 0, 2'b11, 1, 2); tick();
        chk("t3_occ_drain", bus.occupancy, 0);

        // Memory ordering, unit 0 only
        drive(1, w, 1, 2'b11, 0, 0); tick();
        drive(1, l, 1, 2'b11, 0, 0); expect_issue(w, 0, 1); tick();
        drive(1, s, 0, 2'b11, 0, 0);
        chk("t4_lw_blocked", bus.issue_valid, 0);
        tick();
        drive(0, NOP, 0, 2'b11, 0, 0);
        chk("t4_sw_behind_lw", bus.issue_valid, 0);
        tick();
        drive(0, NOP, 0, 2'b11, 1, 0); tick();
        drive(0, NOP, 0, 2'b10, 0, 0);
        chk("t4_mem_needs_unit0", bus.issue_valid, 0);
        tick();
        drive(0, NOP, 0, 2'b11, 0, 0);
        chk("t4_lw_unit", bus.issue_unit, 0);
        expect_issue(l, 1, 0); tick();
        drive(0, NOP, 0, 2'b11, 0, 0);
        chk("t4_sw_unit", bus.issue_unit, 0);
        expect_issue(s, 2, 0); tick();
        drive(0, NOP, 0, 2'b11, 1, 1); tick();
        drive(0, NOP, 0, 2'b11, 1, 2); tick();
        chk("t4_occ_drain", bus.occupancy, 0);

        // Full table: free, issue and held allocation in one cycle
        for (int k = 0; k < 4; k++) begin
            drive(1, t[k], 1, 2'b00, 0, 0); tick();
        end
        drive(0, NOP, 0, 2'b01, 0, 0); expect_issue(t[0], 0, 0); tick();
        drive(0, NOP, 0, 2'b11, 0, 0); expect_issue(t[1], 1, 1); tick();
        drive(0, NOP, 0, 2'b11, 0, 0); expect_issue(t[2], 2, 1); tick();
        drive(1, u, 1, 2'b11, 1, 2); expect_issue(t[3], 3, 1);
        chk("t5_qready_full", bus.queue_ready, 0);
        tick();
        chk("t5_occ_no_alloc", bus.occupancy, 3);
        chk("t5_qready_next", bus.queue_ready, 1);
        drive(1, u, 1, 2'b00, 0, 0); tick();
        chk("t5_occ_alloc", bus.occupancy, 4);
        chk("t5_rd_slot2", bus.rds_in_scheduler[14:10], 20);
        drive(0, NOP, 0, 2'b11, 0, 0); expect_issue(u, 2, 1); tick();

        // Asynchronous reset with three entries in flight
        drive(0, NOP, 0, 2'b00, 1, 0); tick();
        chk("t6_occ_inflight", bus.occupancy, 3);
        drive(0, NOP, 0, 2'b11, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_occ", bus.occupancy, 0);
        chk("t6_async_qready", bus.queue_ready, 1);
        chk("t6_async_valid", bus.issue_valid, 0);
        chk("t6_async_instr", bus.issue_instruction, NOP);
        chk("t6_async_rds", bus.rds_in_scheduler, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, NOP, 0, 2'b11, 1, 1); tick();
        chk("t6_wb_ignored_occ", bus.occupancy, 0);
        chk("t6_wb_ignored_valid", bus.issue_valid, 0);
        drive(0, NOP, 0, 2'b11, 1, 3); tick();
        chk("t6_wb_ignored_occ2", bus.occupancy, 0);

        chk("sb_empty", 160'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
